// File: rtl/time_set_keys_pkg.sv
// Shared constants and types for the time-setting button front end.
package time_set_pkg;

    // Field selected for adjustment; MODE_RUN means the clock simply runs.
    localparam logic [1:0] MODE_RUN  = 2'd0;
    localparam logic [1:0] MODE_HOUR = 2'd1;
    localparam logic [1:0] MODE_MIN  = 2'd2;
    localparam logic [1:0] MODE_SEC  = 2'd3;

    // Button slots inside the debouncer vector.
    localparam int BTN_MODE = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DN   = 2;
    localparam int NUM_BTN  = 3;

    // Shared up/down auto-repeat state machine.
    typedef enum logic [2:0] {
        IDLE,
        HOLD_UP,
        HOLD_DN,
        RPT_UP,
        RPT_DN
    } rpt_state_t;

    // Larger of two sizing parameters, used to size the shared repeat timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/time_set_keys_if.sv
// Button inputs and clock-counter controls of the time-setting front end.
interface time_set_keys_if;
    logic       btn_mode_n;
    logic       btn_up_n;
    logic       btn_down_n;
    logic [1:0] mode;
    logic       inc;
    logic       dec;
    logic       setting;

    // Board / stimulus side: drives the raw keys, observes the controls.
    modport master (
        output btn_mode_n, btn_up_n, btn_down_n,
        input  mode, inc, dec, setting
    );

    // Front-end side: consumes the raw keys, produces the controls.
    modport slave (
        input  btn_mode_n, btn_up_n, btn_down_n,
        output mode, inc, dec, setting
    );
endinterface

// File: rtl/time_set_keys_btn_debounce.sv
// One raw active-low key: 2-flop synchronizer, stability-count debounce,
// and a registered one-cycle press event on each debounced press.
module btn_debounce
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk50,
    input  logic key_n,
    input  logic raw_n,
    output logic pressed,
    output logic press_evt
);
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;

    // Bring the asynchronous key into clk50; preset to released.
    always_ff @(posedge clk50 or negedge key_n) begin
        if (!key_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], raw_n};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        evt_d = 1'b0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync_q[1];
                cnt_d = '0;
                evt_d = ~sync_q[1];   // only released -> pressed counts
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk50 or negedge key_n) begin
        if (!key_n) begin
            db_q  <= 1'b1;
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign pressed   = ~db_q;
    assign press_evt = evt_q;

endmodule

// File: rtl/time_set_keys.sv
// Time-setting front end: debounced keys, field-select mode with idle
// timeout, and inc/dec pulses with hold-to-repeat.
module time_set_keys
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int TIMEOUT_CYC  = 500000000
) (
    input  logic            clk50,
    input  logic            key_n,
    time_set_keys_if.slave  bus
);
    localparam int               TMR_W      = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam int               TO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] pressed_vec;
    logic [NUM_BTN-1:0] evt_vec;

    assign raw_vec[BTN_MODE] = bus.btn_mode_n;
    assign raw_vec[BTN_UP]   = bus.btn_up_n;
    assign raw_vec[BTN_DN]   = bus.btn_down_n;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_db (
                .clk50     (clk50),
                .key_n     (key_n),
                .raw_n     (raw_vec[gi]),
                .pressed   (pressed_vec[gi]),
                .press_evt (evt_vec[gi])
            );
        end
    endgenerate

    // Only the press event of the mode key matters, not its held level.
    logic unused_mode_pressed;
    assign unused_mode_pressed = pressed_vec[BTN_MODE];

    logic mode_evt, up_evt, dn_evt, up_pressed, dn_pressed;
    assign mode_evt   = evt_vec[BTN_MODE];
    assign up_evt     = evt_vec[BTN_UP];
    assign dn_evt     = evt_vec[BTN_DN];
    assign up_pressed = pressed_vec[BTN_UP];
    assign dn_pressed = pressed_vec[BTN_DN];

    rpt_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       mode_q, mode_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             inc_q, dec_q, setting_q;
    logic             pulse_up, pulse_dn;

    // Repeat FSM: first pulse on press, then delay, then fixed-rate repeats.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        pulse_up = 1'b0;
        pulse_dn = 1'b0;
        if (mode_evt) begin
            // A mode change swallows any pending up/down activity.
            state_d = IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmr_d = '0;
                    if (up_evt && !dn_pressed) begin
                        pulse_up = 1'b1;
                        state_d  = HOLD_UP;
                    end else if (dn_evt && !up_pressed) begin
                        pulse_dn = 1'b1;
                        state_d  = HOLD_DN;
                    end
                end
                HOLD_UP, RPT_UP: begin
                    if (!up_pressed || dn_pressed) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == ((state_q == HOLD_UP) ? DELAY_LAST : RATE_LAST)) begin
                        pulse_up = 1'b1;
                        state_d  = RPT_UP;
                        tmr_d    = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                HOLD_DN, RPT_DN: begin
                    if (!dn_pressed || up_pressed) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == ((state_q == HOLD_DN) ? DELAY_LAST : RATE_LAST)) begin
                        pulse_dn = 1'b1;
                        state_d  = RPT_DN;
                        tmr_d    = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Mode stepping and the idle timeout that drops back to run.
    always_comb begin
        mode_d = mode_q;
        to_d   = to_q;
        if (mode_evt) begin
            mode_d = mode_q + 2'd1;
            to_d   = '0;
        end else if (mode_q == MODE_RUN) begin
            to_d = '0;
        end else if (up_evt || dn_evt || pulse_up || pulse_dn) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            mode_d = MODE_RUN;
            to_d   = '0;
        end else begin
            to_d = to_q + TO_W'(1);
        end
    end

    // State and output registers; pulses are suppressed while running.
    always_ff @(posedge clk50 or negedge key_n) begin
        if (!key_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            mode_q    <= MODE_RUN;
            to_q      <= '0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            setting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            mode_q    <= mode_d;
            to_q      <= to_d;
            inc_q     <= pulse_up && (mode_q != MODE_RUN);
            dec_q     <= pulse_dn && (mode_q != MODE_RUN);
            setting_q <= (mode_d != MODE_RUN);
        end
    end

    assign bus.mode    = mode_q;
    assign bus.inc     = inc_q;
    assign bus.dec     = dec_q;
    assign bus.setting = setting_q;

endmodule

// File: tb/tb_time_set_keys.sv
// Scoreboard bench for time_set_keys with short debounce/repeat/timeout.
module tb_time_set_keys;
    import time_set_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;
    localparam int TO  = 100;
    // Key driven at a negedge with cycle count c: outputs change at edge c+LAT.
    localparam int LAT = DEB + 3;

    localparam int EV_INC  = 0;
    localparam int EV_DEC  = 1;
    localparam int EV_MODE = 2;

    logic clk50 = 1'b0;
    logic key_n = 1'b0;
    int   cyc   = 0;

    time_set_keys_if bus ();

    time_set_keys #(
        .DEBOUNCE_CYC (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk50 (clk50),
        .key_n (key_n),
        .bus   (bus)
    );

    always #5 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Match one observed output event against the oldest expectation.
    task automatic take_evt(input int kind, input int val);
        ev_t e;
        $display("evt kind=%0d val=%0d cycle=%0d", kind, val, cyc);
        if (exp_q.size() == 0) begin
            check($sformatf("unexpected_evt_kind%0d_cycle", kind), cyc, -1);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", kind, e.kind);
            check($sformatf("evt_cycle_kind%0d", kind), cyc, e.cyc);
            if (kind == EV_MODE) begin
                check("mode_val", val, e.val);
                check("setting_with_mode", int'(bus.setting), int'(e.val != 0));
            end
        end
    endtask

    // Output monitor, sampling on the falling edge.
    initial begin
        int prev_mode;
        prev_mode = 0;
        forever begin
            @(negedge clk50);
            if (!key_n) begin
                prev_mode = 0;
            end else begin
                if (int'(bus.mode) != prev_mode) begin
                    take_evt(EV_MODE, int'(bus.mode));
                    prev_mode = int'(bus.mode);
                end
                if (bus.inc) take_evt(EV_INC, 0);
                if (bus.dec) take_evt(EV_DEC, 0);
                check("inc_dec_exclusive", int'(bus.inc & bus.dec), 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            BTN_MODE: bus.btn_mode_n = v;
            BTN_UP:   bus.btn_up_n   = v;
            default:  bus.btn_down_n = v;
        endcase
    endtask

    // Drive a key low at the next negedge; returns that cycle count.
    task automatic press_start(input int which, output int c);
        @(negedge clk50);
        c = cyc;
        set_btn(which, 1'b0);
    endtask

    task automatic mode_press(input int new_mode, output int t);
        int c;
        press_start(BTN_MODE, c);
        t = c + LAT;
        push_exp(EV_MODE, new_mode, t);
        idle(10);
        set_btn(BTN_MODE, 1'b1);
        idle(8);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mode"},    int'(bus.mode),    0);
        check({tag, "_inc"},     int'(bus.inc),     0);
        check({tag, "_dec"},     int'(bus.dec),     0);
        check({tag, "_setting"}, int'(bus.setting), 0);
    endtask

    initial begin
        int c, t0, t1, m3;
        bus.btn_mode_n = 1'b1;
        bus.btn_up_n   = 1'b1;
        bus.btn_down_n = 1'b1;

        // Reset state.
        idle(3);
        check_outputs_zero("reset");
        key_n = 1'b1;
        idle(5);

        // 1: two 3-cycle glitches rejected, then a real press -> mode 1.
        for (int g = 0; g < 2; g++) begin
            @(negedge clk50);
            set_btn(BTN_MODE, 1'b0);
            idle(3);
            set_btn(BTN_MODE, 1'b1);
            idle(2);
        end
        press_start(BTN_MODE, c);
        push_exp(EV_MODE, 1, c + LAT);
        idle(10);
        set_btn(BTN_MODE, 1'b1);
        idle(8);
        check("s1_pending", exp_q.size(), 0);

        // 2: minute mode, hold up -> pulses at t0, +20, +28, +36, +44.
        mode_press(2, t1);
        press_start(BTN_UP, c);
        t0 = c + LAT;
        push_exp(EV_INC, 0, t0);
        push_exp(EV_INC, 0, t0 + RD);
        for (int k = 1; k <= 3; k++) push_exp(EV_INC, 0, t0 + RD + k * RR);
        idle(t0 + 42 - c);
        set_btn(BTN_UP, 1'b1);
        idle(14);
        check("s2_pending", exp_q.size(), 0);

        // 3a: step to second, then wrap to run.
        mode_press(3, t1);
        mode_press(0, t1);

        // 3b: up in run mode produces no pulse.
        press_start(BTN_UP, c);
        idle(20);
        set_btn(BTN_UP, 1'b1);
        idle(12);
        check("s3b_pending", exp_q.size(), 0);

        // 3c: hour mode, hold down, then add up: one dec only.
        mode_press(1, t1);
        press_start(BTN_DN, c);
        t1 = c + LAT;
        push_exp(EV_DEC, 0, t1);
        idle(12);
        set_btn(BTN_UP, 1'b0);
        idle(40);
        set_btn(BTN_UP, 1'b1);
        set_btn(BTN_DN, 1'b1);
        idle(12);
        check("s3c_pending", exp_q.size(), 0);

        // 4: full wrap sequences, then timeout out of second mode.
        mode_press(2, t1);
        mode_press(3, t1);
        mode_press(0, t1);
        mode_press(1, t1);
        mode_press(2, t1);
        mode_press(3, t1);
        mode_press(0, t1);
        mode_press(1, t1);
        mode_press(2, t1);
        mode_press(3, m3);
        push_exp(EV_MODE, 0, m3 + TO);
        idle(TO);
        check("s4_pending", exp_q.size(), 0);

        // 5: reset while auto-repeating.
        mode_press(1, t1);
        press_start(BTN_UP, c);
        t0 = c + LAT;
        push_exp(EV_INC, 0, t0);
        push_exp(EV_INC, 0, t0 + RD);
        idle(t0 + RD + 4 - c);
        key_n = 1'b0;
        #1;
        check_outputs_zero("midhold_reset");
        check("s5_pre_reset_pending", exp_q.size(), 0);
        idle(2);
        key_n = 1'b1;
        idle(30);
        mode_press(1, t1);   // up still held: must stay silent
        idle(40);
        set_btn(BTN_UP, 1'b1);
        idle(12);
        check("s5_held_pending", exp_q.size(), 0);
        press_start(BTN_UP, c);
        push_exp(EV_INC, 0, c + LAT);
        idle(10);
        set_btn(BTN_UP, 1'b1);
        idle(12);
        check("s5_final_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
